// File: rtl/fft_pkg.sv
// Shared definitions for the streaming FFT pipeline stages.
// Holds the frame-sync state enum and the delay-depth helper.
package fft_pkg;

    typedef enum logic [1:0] {
        StSync,
        StFill,
        StRun
    } state_e;

    // Delay depth of an R2SDF stage whose frame counter is cbw bits wide.
    function automatic int unsigned delay_depth(input int unsigned cbw);
        return 32'd1 << (cbw - 32'd1);
    endfunction

endpackage

// File: rtl/sdf_delay_ram.sv
// Single-address delay line with asynchronous read and synchronous write.
// A read and a write at the same address in one cycle return the old contents.
module sdf_delay_ram #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 18,
    localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AddrW-1:0] addr,
    input  logic [Width-1:0] wdata,
    output logic [Width-1:0] rdata
);

    logic [Width-1:0] mem_q [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/sdf_butterfly.sv
// Radix-2 single-path delay-feedback DIF butterfly stage: sums in the second half of
// each frame, the deferred differences in the first half of the following frame.
module sdf_butterfly
    import fft_pkg::*;
#(
    parameter int unsigned DBW = 8,
    parameter int unsigned CBW = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vld_in,
    input  logic [CBW-1:0]        cnt,
    input  logic signed [DBW-1:0] din_re,
    input  logic signed [DBW-1:0] din_im,
    output logic                  vld_out,
    output logic [CBW-1:0]        cnt_out,
    output logic signed [DBW:0]   dout_re,
    output logic signed [DBW:0]   dout_im,
    output logic [CBW-2:0]        tw_idx,
    output logic                  err
);

    localparam int unsigned D     = delay_depth(CBW);
    localparam int unsigned RamW  = 2 * (DBW + 1);
    localparam logic [CBW-1:0] CntOne = 1;

    state_e                state_q, state_d;
    logic [CBW-1:0]        last_q, last_d;
    logic                  vld_out_q, vld_out_d;
    logic                  err_q, err_d;
    logic signed [DBW:0]   dout_re_q, dout_re_d;
    logic signed [DBW:0]   dout_im_q, dout_im_d;
    logic [CBW-1:0]        cnt_out_q, cnt_out_d;
    logic [CBW-2:0]        tw_idx_q, tw_idx_d;

    logic [CBW-2:0]        k;
    logic                  second_half;
    logic [CBW-1:0]        cnt_exp;
    logic signed [DBW:0]   din_re_x, din_im_x;
    logic signed [DBW:0]   h_re, h_im;
    logic signed [DBW:0]   sum_re, sum_im, diff_re, diff_im;
    logic                  ram_we;
    logic [RamW-1:0]       ram_wdata, ram_rdata;
    logic                  process;
    state_e                eff_state;

    assign k           = cnt[CBW-2:0];
    assign second_half = cnt[CBW-1];
    assign cnt_exp     = last_q + CntOne;

    assign din_re_x = {din_re[DBW-1], din_re};
    assign din_im_x = {din_im[DBW-1], din_im};
    assign h_re     = ram_rdata[RamW-1 -: DBW+1];
    assign h_im     = ram_rdata[DBW:0];

    // Exact in DBW+1 bits: h is a sign-extended first-half sample in the second half.
    assign sum_re  = h_re + din_re_x;
    assign sum_im  = h_im + din_im_x;
    assign diff_re = h_re - din_re_x;
    assign diff_im = h_im - din_im_x;

    sdf_delay_ram #(
        .Depth(D),
        .Width(RamW)
    ) u_delay_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (k),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        vld_out_d = 1'b0;
        err_d     = 1'b0;
        dout_re_d = dout_re_q;
        dout_im_d = dout_im_q;
        cnt_out_d = cnt_out_q;
        tw_idx_d  = tw_idx_q;
        ram_we    = 1'b0;
        ram_wdata = second_half ? {diff_re, diff_im} : {din_re_x, din_im_x};
        process   = 1'b0;
        eff_state = state_q;

        if (vld_in && !rst) begin
            case (state_q)
                StSync: begin
                    if (cnt == '0) begin
                        process   = 1'b1;
                        eff_state = StFill;
                    end
                end
                default: begin
                    if (cnt != cnt_exp) begin
                        // A break that lands on cnt=0 resynchronises immediately.
                        err_d = 1'b1;
                        if (cnt == '0) begin
                            process   = 1'b1;
                            eff_state = StFill;
                        end else begin
                            eff_state = StSync;
                        end
                    end else begin
                        process = 1'b1;
                    end
                end
            endcase
            state_d = eff_state;

            if (process) begin
                last_d = cnt;
                ram_we = 1'b1;
                if (second_half) begin
                    vld_out_d = 1'b1;
                    dout_re_d = sum_re;
                    dout_im_d = sum_im;
                    cnt_out_d = cnt;
                    tw_idx_d  = '0;
                end else if (eff_state == StRun) begin
                    vld_out_d = 1'b1;
                    dout_re_d = h_re;
                    dout_im_d = h_im;
                    cnt_out_d = cnt;
                    tw_idx_d  = k;
                end
                if (eff_state == StFill && cnt == '1) begin
                    state_d = StRun;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StSync;
            last_q    <= '0;
            vld_out_q <= 1'b0;
            err_q     <= 1'b0;
            dout_re_q <= '0;
            dout_im_q <= '0;
            cnt_out_q <= '0;
            tw_idx_q  <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            vld_out_q <= vld_out_d;
            err_q     <= err_d;
            dout_re_q <= dout_re_d;
            dout_im_q <= dout_im_d;
            cnt_out_q <= cnt_out_d;
            tw_idx_q  <= tw_idx_d;
        end
    end

    assign vld_out = vld_out_q;
    assign err     = err_q;
    assign dout_re = dout_re_q;
    assign dout_im = dout_im_q;
    assign cnt_out = cnt_out_q;
    assign tw_idx  = tw_idx_q;

endmodule

// File: tb/tb_sdf_butterfly.sv
// Scoreboard bench for sdf_butterfly: a frame-level reference model queues expected
// outputs; a negedge monitor pops and compares whenever the stage presents one.
module tb_sdf_butterfly;

    localparam int N = 8;
    localparam int D = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              vld_in = 1'b0;
    logic [2:0]        cnt = '0;
    logic signed [7:0] din_re = '0;
    logic signed [7:0] din_im = '0;
    logic              vld_out;
    logic [2:0]        cnt_out;
    logic signed [8:0] dout_re;
    logic signed [8:0] dout_im;
    logic [1:0]        tw_idx;
    logic              err;

    sdf_butterfly #(
        .DBW(8),
        .CBW(3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .vld_in (vld_in),
        .cnt    (cnt),
        .din_re (din_re),
        .din_im (din_im),
        .vld_out(vld_out),
        .cnt_out(cnt_out),
        .dout_re(dout_re),
        .dout_im(dout_im),
        .tw_idx (tw_idx),
        .err    (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_err;
        int re;
        int im;
        int c;
        int tw;
    } exp_t;

    exp_t sb[$];
    int   log_re[$];
    int   log_im[$];
    int   exp_re_q[$];
    int   exp_im_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: one pending difference per butterfly pair, valid only once the
    // second half of a frame seen since the last sync has produced it.
    bit m_synced = 0;
    int m_last = 0;
    int m_line_re[D];
    int m_line_im[D];
    bit m_pend[D];

    function automatic void model_reset();
        m_synced = 0;
    endfunction

    function automatic void model_push_data(input int re, input int im, input int c, input int tw);
        exp_t e;
        e.is_err = 0; e.re = re; e.im = im; e.c = c; e.tw = tw;
        sb.push_back(e);
    endfunction

    function automatic void model_accept(input int c, input int re, input int im);
        exp_t e;
        int   k;
        int   h_re, h_im;
        if (m_synced && c != (m_last + 1) % N) begin
            e.is_err = 1; e.re = 0; e.im = 0; e.c = 0; e.tw = 0;
            sb.push_back(e);
            m_synced = 0;
        end
        if (!m_synced) begin
            if (c != 0) return;
            m_synced = 1;
            for (int i = 0; i < D; i++) m_pend[i] = 0;
        end
        m_last = c;
        k = c % D;
        h_re = m_line_re[k];
        h_im = m_line_im[k];
        if (c < D) begin
            if (m_pend[k]) model_push_data(h_re, h_im, c, k);
            m_line_re[k] = re;
            m_line_im[k] = im;
        end else begin
            model_push_data(h_re + re, h_im + im, c, 0);
            m_line_re[k] = h_re - re;
            m_line_im[k] = h_im - im;
            m_pend[k] = 1;
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (vld_out || err) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: vld_out=%0b err=%0b cnt_out=%0d re=%0d, none required",
                         vld_out, err, cnt_out, dout_re);
            end else begin
                e = sb.pop_front();
                if (e.is_err) begin
                    if (!(err && !vld_out)) begin
                        errors++;
                        $display("FAIL err_pulse: got err=%0b vld_out=%0b, required err=1 vld_out=0",
                                 err, vld_out);
                    end
                end else if (err || !vld_out || int'(dout_re) != e.re || int'(dout_im) != e.im ||
                             int'(cnt_out) != e.c || int'(tw_idx) != e.tw) begin
                    errors++;
                    $display("FAIL data_out: got err=%0b vld=%0b re=%0d im=%0d cnt=%0d tw=%0d, required re=%0d im=%0d cnt=%0d tw=%0d",
                             err, vld_out, dout_re, dout_im, cnt_out, tw_idx,
                             e.re, e.im, e.c, e.tw);
                end
            end
        end
        if (vld_out) begin
            log_re.push_back(int'(dout_re));
            log_im.push_back(int'(dout_im));
        end
    end

    task automatic send(input bit v, input int c, input int re, input int im);
        @(posedge clk);
        #1;
        vld_in = v;
        cnt    = c[2:0];
        din_re = re[7:0];
        din_im = im[7:0];
        if (v) model_accept(c, re, im);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) send(0, 0, 0, 0);
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (vld_out !== 1'b0 || err !== 1'b0 || dout_re !== '0 || dout_im !== '0 ||
            cnt_out !== '0 || tw_idx !== '0) begin
            errors++;
            $display("FAIL %s: got vld=%0b err=%0b re=%0d im=%0d cnt=%0d tw=%0d, required all 0",
                     name, vld_out, err, dout_re, dout_im, cnt_out, tw_idx);
        end
    endtask

    // rst is raised together with an optional accepted sample, which must be dropped.
    task automatic do_reset(input bit v, input int c, input int re, input int im);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        vld_in = v;
        cnt    = c[2:0];
        din_re = re[7:0];
        din_im = im[7:0];
        model_reset();
        @(posedge clk);
        #1;
        rst    = 1'b0;
        vld_in = 1'b0;
        check_reset_outputs("reset_outputs");
        log_re.delete();
        log_im.delete();
    endtask

    task automatic check_log(input string name);
        checks++;
        if (log_re.size() != exp_re_q.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d outputs, required %0d", name, log_re.size(),
                     exp_re_q.size());
        end else begin
            for (int i = 0; i < exp_re_q.size(); i++) begin
                checks++;
                if (log_re[i] != exp_re_q[i] || log_im[i] != exp_im_q[i]) begin
                    errors++;
                    $display("FAIL %s_%0d: got re=%0d im=%0d, required re=%0d im=%0d", name, i,
                             log_re[i], log_im[i], exp_re_q[i], exp_im_q[i]);
                end
            end
        end
    endtask

    task automatic ramp_frames(input bit stall, input int re_sign, input int im_sign);
        for (int c = 0; c < N; c++) begin
            send(1, c, re_sign * (c + 1), im_sign * (c + 1));
            if (stall) idle(1);
        end
        for (int c = 0; c < N; c++) begin
            send(1, c, 0, 0);
            if (stall) idle(1);
        end
        idle(3);
    endtask

    function automatic int rand_sample();
        int r;
        r = int'($urandom_range(0, 7));
        if (r == 0) return -128;
        if (r == 1) return 127;
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    initial begin
        int c;
        int vals[$];
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("initial_reset");

        // Ramp 1..8 then a zero frame.
        do_reset(0, 0, 0, 0);
        ramp_frames(0, 1, 0);
        exp_re_q = '{6, 8, 10, 12, -4, -4, -4, -4, 0, 0, 0, 0};
        exp_im_q = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        check_log("ramp");

        // Same ramp with a stall after every sample.
        do_reset(0, 0, 0, 0);
        ramp_frames(1, 1, 0);
        check_log("stall");

        // Imaginary path alone.
        do_reset(0, 0, 0, 0);
        ramp_frames(0, 0, -1);
        exp_re_q = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        exp_im_q = '{-6, -8, -10, -12, 4, 4, 4, 4, 0, 0, 0, 0};
        check_log("imag");

        // Range extremes.
        do_reset(0, 0, 0, 0);
        for (int i = 0; i < N; i++) send(1, i, (i < D) ? -128 : 127, 0);
        for (int i = 0; i < N; i++) send(1, i, 0, 0);
        idle(3);
        exp_re_q = '{-1, -1, -1, -1, -255, -255, -255, -255, 0, 0, 0, 0};
        exp_im_q = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        check_log("range");

        // Discontinuity in RUN: 2 -> 5, then resync at the next cnt=0.
        do_reset(0, 0, 0, 0);
        for (int i = 0; i < N; i++) send(1, i, rand_sample(), rand_sample());
        vals = '{0, 1, 2, 5, 6, 7};
        foreach (vals[i]) send(1, vals[i], rand_sample(), rand_sample());
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < N; i++) send(1, i, rand_sample(), rand_sample());
        idle(3);

        // Mid-frame reset at cnt=6 while in RUN.
        do_reset(0, 0, 0, 0);
        for (int i = 0; i < N; i++) send(1, i, rand_sample(), rand_sample());
        for (int i = 0; i < 6; i++) send(1, i, rand_sample(), rand_sample());
        do_reset(1, 6, 55, -7);
        send(1, 7, rand_sample(), rand_sample());
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < N; i++) send(1, i, rand_sample(), rand_sample());
        idle(3);

        // Random stalls, counter glitches and occasional resets.
        do_reset(0, 0, 0, 0);
        c = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset($urandom_range(0, 1) == 1, c, rand_sample(), rand_sample());
            end else if ($urandom_range(0, 3) == 0) begin
                send(0, int'($urandom_range(0, 7)), rand_sample(), rand_sample());
            end else begin
                if ($urandom_range(0, 39) == 0) c = int'($urandom_range(0, 7));
                send(1, c, rand_sample(), rand_sample());
                c = (c + 1) % N;
            end
        end
        idle(4);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d outputs still outstanding, required 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
